// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - captures an 8-bit temperature and scans it onto a 3-digit 7-segment display
module seg_scan_mux #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] decimalTemp,
    input  logic       display,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, LATCH} stateType;

    stateType    state;
    stateType    nextState;
    logic        dispQ;
    logic        armed;
    logic        capture;
    logic [2:0]  iterCnt;
    logic [19:0] dabble;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        shown;
    logic [CW-1:0] scanCnt;
    logic [1:0]  digitIdx;
    logic [3:0]  digitVal;
    logic [2:0]  anCode;
    logic        lit;

    function automatic logic [19:0] dabbleStep(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] segEncode(input logic [3:0] d);
        case (d)
            4'd0:    segEncode = 7'b1000000;
            4'd1:    segEncode = 7'b1111001;
            4'd2:    segEncode = 7'b0100100;
            4'd3:    segEncode = 7'b0110000;
            4'd4:    segEncode = 7'b0011001;
            4'd5:    segEncode = 7'b0010010;
            4'd6:    segEncode = 7'b0000010;
            4'd7:    segEncode = 7'b1111000;
            4'd8:    segEncode = 7'b0000000;
            4'd9:    segEncode = 7'b0010000;
            default: segEncode = 7'b1111111;
        endcase
    endfunction

    // armed stays low after reset until display is seen low, so a level held through reset never captures
    assign capture = display & ~dispQ & armed;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dispQ <= 1'b0;
            armed <= 1'b0;
        end else begin
            dispQ <= display;
            if (!display) armed <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (capture) nextState = CONVERT;
            CONVERT: if (iterCnt == 3'd7) nextState = LATCH;
            LATCH:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONVERT) || (state == LATCH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            iterCnt  <= 3'd0;
            dabble   <= 20'd0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
            shown    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        dabble  <= {12'd0, decimalTemp};
                        iterCnt <= 3'd0;
                    end
                end
                CONVERT: begin
                    dabble  <= dabbleStep(dabble);
                    iterCnt <= iterCnt + 3'd1;
                end
                LATCH: begin
                    hundreds <= dabble[19:16];
                    tens     <= dabble[15:12];
                    ones     <= dabble[11:8];
                    shown    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scanCnt  <= '0;
            digitIdx <= 2'd0;
        end else if (scanCnt == SCAN_LAST) begin
            scanCnt  <= '0;
            digitIdx <= (digitIdx == 2'd2) ? 2'd0 : digitIdx + 2'd1;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    // leading-zero suppression: tens only blanks when hundreds is also zero
    always_comb begin
        digitVal = ones;
        anCode   = 3'b110;
        lit      = 1'b1;
        case (digitIdx)
            2'd1: begin
                digitVal = tens;
                anCode   = 3'b101;
                lit      = (hundreds != 4'd0) || (tens != 4'd0);
            end
            2'd2: begin
                digitVal = hundreds;
                anCode   = 3'b011;
                lit      = (hundreds != 4'd0);
            end
            default: ;
        endcase
        if (!display || !shown) lit = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            an  <= 3'b111;
            seg <= 7'b1111111;
        end else if (lit) begin
            an  <= anCode;
            seg <= segEncode(digitVal);
        end else begin
            an  <= 3'b111;
            seg <= 7'b1111111;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard bench for seg_scan_mux with SCAN_DIV=4
module tb_seg_scan_mux;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] decimalTemp;
    logic       display;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
    } expType;

    expType sbq[$];
    int errors = 0;
    int checks = 0;
    logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg_scan_mux #(.SCAN_DIV(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .decimalTemp(decimalTemp),
        .display(display),
        .seg(seg),
        .an(an),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushDigits(input int v);
        int h, t, o;
        expType e;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 4; c++) begin
                e.an  = 3'b111;
                e.seg = 7'b1111111;
                if (j == 0) begin
                    e.an = 3'b110; e.seg = segTab[o];
                end else if (j == 1 && !(h == 0 && t == 0)) begin
                    e.an = 3'b101; e.seg = segTab[t];
                end else if (j == 2 && h != 0) begin
                    e.an = 3'b011; e.seg = segTab[h];
                end
                sbq.push_back(e);
            end
        end
    endtask

    task automatic lowerDisplay;
        display = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic convert(input string tag, input int v, input bit toggle);
        int cnt;
        pushDigits(v);
        decimalTemp = v[7:0];
        display = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0) chk({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
            if (busy) cnt++;
            if (toggle && (i == 1 || i == 3 || i == 5 || i == 7)) begin
                display = ~display;
                decimalTemp = 8'($urandom);
            end
            if (i > 0 && !busy) break;
        end
        chk({tag, "_busy_cycles"}, cnt, 32'd9);
    endtask

    task automatic checkScan(input string tag);
        int n;
        expType e;
        n = 0;
        while (an !== 3'b110 && n < 64) begin tick(); n++; end
        while (an === 3'b110 && n < 64) begin tick(); n++; end
        while (an !== 3'b110 && n < 64) begin tick(); n++; end
        checks++;
        assert (n < 64) else begin
            errors++;
            $error("FAIL %s_sync observed=%0d cycles expected=<64", tag, n);
        end
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            e = sbq.pop_front();
            chk($sformatf("%s_an%0d", tag, c), {29'd0, an}, {29'd0, e.an});
            chk($sformatf("%s_seg%0d", tag, c), {25'd0, seg}, {25'd0, e.seg});
        end
        sbq.delete();
    endtask

    initial begin
        RST = 1'b1;
        display = 1'b0;
        decimalTemp = 8'd0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_an", {29'd0, an}, 32'h7);
        chk("rst_seg", {25'd0, seg}, 32'h7f);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        RST = 1'b0;
        tick();

        convert("t5", 5, 1'b0);
        checkScan("t5");
        lowerDisplay();
        convert("t20", 20, 1'b0);
        checkScan("t20");
        lowerDisplay();
        convert("t255", 255, 1'b0);
        checkScan("t255");
        lowerDisplay();
        convert("t0", 0, 1'b0);
        checkScan("t0");

        lowerDisplay();
        convert("t123tog", 123, 1'b1);
        checkScan("t123tog");

        display = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("low_blank%0d", i), {29'd0, an}, 32'h7);
        end
        convert("t42", 42, 1'b0);
        checkScan("t42");

        lowerDisplay();
        decimalTemp = 8'd77;
        display = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        RST = 1'b1;
        tick();
        chk("abort_an", {29'd0, an}, 32'h7);
        chk("abort_seg", {25'd0, seg}, 32'h7f);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("post_rst_an%0d", i), {29'd0, an}, 32'h7);
            chk($sformatf("post_rst_busy%0d", i), {31'd0, busy}, 32'd0);
        end
        lowerDisplay();
        convert("t99", 99, 1'b0);
        checkScan("t99");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is driven; legal range 2..2^20.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port decimalTemp  input  8  unsigned binary temperature from the 7-segment driver stage, 0..255.
REQ-005 SHALL have port display  input  1  enable from the driver; rising edge requests capture, low level blanks the display.
REQ-006 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-007 SHALL have port an  output  3  active-low digit enables: an[0] ones, an[1] tens, an[2] hundreds.
REQ-008 SHALL have port busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-009 SHALL register display every cycle (disp_q); a capture event is display=1 and disp_q=0 at an edge k.
REQ-010 SHALL implement FSM states IDLE, CONVERT, LATCH; IDLE->CONVERT on a capture event, CONVERT->LATCH after 8 iterations, LATCH->IDLE unconditionally.
REQ-011 SHALL copy decimalTemp into the shift register at edge k; later changes to decimalTemp SHALL NOT affect the result.
REQ-012 SHALL perform one double-dabble iteration per cycle at edges k+1..k+8: add 3 to any BCD nibble >=5, then shift left one bit.
REQ-013 SHALL load hundreds (0..2), tens and ones (0..9) display registers and set a shown flag at edge k+9; busy SHALL be 1 after edges k..k+8 and 0 after edge k+9.
REQ-014 SHALL ignore capture events while in CONVERT or LATCH (no restart, no queuing); the previously latched value SHALL stay displayed during conversion.
REQ-015 SHALL run a scan counter 0..SCAN_DIV-1 continuously; at count SCAN_DIV-1 it wraps to 0 and the digit index advances 0->1->2->0.
REQ-016 SHALL register seg and an from the digit index and display registers, one cycle after the index changes.
REQ-017 SHALL drive an=3'b110 for index 0, 3'b101 for index 1, 3'b011 for index 2 when the digit is lit.
REQ-018 SHALL blank the hundreds digit when it is 0, and the tens digit when hundreds and tens are both 0; the ones digit SHALL always be lit.
REQ-019 A blanked digit SHALL drive seg=7'b1111111 and deassert its an bit (1).
REQ-020 SHALL blank all digits (an=3'b111, seg=7'b1111111) while display=0 or shown=0; conversion SHALL still complete if display falls during CONVERT.
REQ-021 SHALL encode segments as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-022 RST=1 at an edge SHALL set FSM=IDLE, disp_q=0, busy=0, scan counter=0, digit index=0, display registers=0, shown=0, an=3'b111, seg=7'b1111111.
REQ-023 RST SHALL take priority over every other event, including mid-conversion; the aborted result SHALL NOT be latched.
REQ-024 A display level already high when RST releases SHALL NOT create a capture event until display goes low and then high again.

Verification (SCAN_DIV=4)
REQ-025 decimalTemp=5, display rises -> busy for 9 cycles; then only an=110 lit with seg=0010010; an[1] and an[2] stay 1.
REQ-026 decimalTemp=20 -> an=110 seg=1000000, an=101 seg=0100100, hundreds blank; each digit lit 4 cycles, in order ones, tens, hundreds.
REQ-027 decimalTemp=255 -> digits 2,5,5 (seg 0100100, 0010010, 0010010); decimalTemp=0 -> only ones lit with seg=1000000.
REQ-028 display toggled every 2 cycles during CONVERT with decimalTemp changing -> single conversion of the value captured at edge k, latched at k+9; no restart.
REQ-029 RST asserted at edge k+4 of a conversion -> all reset values at next edge; the display stays blank until a new display rising edge.
REQ-030 display held low after a completed conversion -> an=111 throughout; raising display again reconverts and shows the current decimalTemp.
